// File: rtl/vga_text_pipe_pkg.sv
// Shared text-mode VGA constants and attribute helpers.
// Geometry, attribute bit fields and the pixel colour rule.
package vga_text_pipe_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int CELL_W    = 8;
  localparam int CELL_H    = 16;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;

  localparam int ATTR_FG_LO = 0;
  localparam int ATTR_FG_HI = 3;
  localparam int ATTR_BG_LO = 4;
  localparam int ATTR_BG_HI = 6;
  localparam int ATTR_BLINK = 7;

  typedef enum logic [2:0] {
    K_CAP  = 3'd2,
    K_FONT = 3'd6,
    K_LOAD = 3'd7
  } cell_phase_e;

  function automatic logic [3:0] cell_pix(
    input logic       px,
    input logic [7:0] attr,
    input logic       hide
  );
    if (px && !hide)
      return attr[ATTR_FG_HI:ATTR_FG_LO];
    return {1'b0, attr[ATTR_BG_HI:ATTR_BG_LO]};
  endfunction

endpackage

// File: rtl/vga_blink_gen.sv
// Frame counter and blink phase for text attributes.
// blink_on flips every BLINK_FRAMES frames.
module vga_blink_gen
  import vga_text_pipe_pkg::*;
#(
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic n_rst,
  input  logic frame_end,
  output logic blink_on
);

  localparam int CW = $clog2(BLINK_FRAMES);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(BLINK_FRAMES - 1));

  // Count frames; toggle the phase on counter wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt      <= '0;
      blink_on <= 1'b0;
    end else if (frame_end) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap)
        blink_on <= ~blink_on;
    end
  end

endmodule

// File: rtl/vga_text_pipe.sv
// Text-mode read pipeline: RAM bytes -> font row -> IRGB.
// Eight-clock latency from cell start to first pixel.
module vga_text_pipe
  import vga_text_pipe_pkg::*;
#(
  parameter int BLINK_FRAMES = 32,
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [9:0]  hx,
  input  logic [9:0]  vy,
  input  logic        n_pixel_ena,
  output logic [11:0] vaddr,
  input  logic [7:0]  text_d,
  input  logic [7:0]  color_d,
  output logic [11:0] font_a,
  input  logic [7:0]  font_d,
  output logic [3:0]  irgb,
  output logic        blink_on
);

  logic [2:0] k;
  logic       cap;
  logic       fnt;
  logic       load;
  logic       frame_end;

  logic [7:0] attr;
  logic       cell_valid;
  logic [7:0] glyph;
  logic [7:0] shift;
  logic [7:0] out_attr;
  logic       out_valid;
  logic       out_hide;
  logic       hide_now;

  assign vaddr = {vy[8:4], hx[9:3]};
  assign k     = hx[2:0];

  assign frame_end = (hx == 10'(H_TOTAL - 1)) &&
                     (vy == 10'(V_TOTAL - 1));

  assign hide_now = attr[ATTR_BLINK] & blink_on;

  // Decode the per-cell phase from the low column bits.
  always_comb begin
    cap  = 1'b0;
    fnt  = 1'b0;
    load = 1'b0;
    unique case (1'b1)
      (k == K_CAP):  cap  = 1'b1;
      (k == K_FONT): fnt  = 1'b1;
      (k == K_LOAD): load = 1'b1;
      default: ;
    endcase
  end

  // Capture RAM bytes and issue the font ROM address.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      attr       <= '0;
      cell_valid <= 1'b0;
      font_a     <= '0;
    end else if (cap) begin
      attr       <= color_d;
      cell_valid <= ~n_pixel_ena;
      font_a     <= {text_d, vy[3:0]};
    end
  end

  // Capture the glyph row returned by the font ROM.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      glyph <= '0;
    else if (fnt)
      glyph <= font_d;
  end

  // Load the output stage and serialize; MSB goes out on load.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift     <= '0;
      out_attr  <= '0;
      out_valid <= 1'b0;
      out_hide  <= 1'b0;
      irgb      <= '0;
    end else if (load) begin
      shift     <= {glyph[6:0], 1'b0};
      out_attr  <= attr;
      out_valid <= cell_valid;
      out_hide  <= hide_now;
      irgb      <= cell_valid ?
                   cell_pix(glyph[7], attr, hide_now) : 4'd0;
    end else begin
      shift <= {shift[6:0], 1'b0};
      irgb  <= out_valid ?
               cell_pix(shift[7], out_attr, out_hide) : 4'd0;
    end
  end

  vga_blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk      (clk),
    .n_rst    (n_rst),
    .frame_end(frame_end),
    .blink_on (blink_on)
  );

endmodule

// File: tb/tb_vga_text_pipe.sv
// Directed bench for the text pixel pipeline.
// Drives hx/vy directly; samples outputs on the falling edge.
module tb_vga_text_pipe;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [9:0]  hx;
  logic [9:0]  vy;
  logic        n_pixel_ena;
  logic [11:0] vaddr;
  logic [7:0]  text_d;
  logic [7:0]  color_d;
  logic [11:0] font_a;
  logic [7:0]  font_d;
  logic [3:0]  irgb;
  logic        blink_on;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] txt, col, fnt;

  always #5 clk = ~clk;

  vga_text_pipe #(
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .hx         (hx),
    .vy         (vy),
    .n_pixel_ena(n_pixel_ena),
    .vaddr      (vaddr),
    .text_d     (text_d),
    .color_d    (color_d),
    .font_a     (font_a),
    .font_d     (font_d),
    .irgb       (irgb),
    .blink_on   (blink_on)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel cycle: drive after the rising edge,
  // return at the falling edge with outputs settled.
  task automatic tick(input int h, input int v);
    @(posedge clk);
    #1;
    hx          = 10'(h);
    vy          = 10'(v);
    n_pixel_ena = !(h < 640 && v < 480);
    text_d      = txt;
    color_d     = col;
    font_d      = fnt;
    @(negedge clk);
  endtask

  logic [3:0] exp_a [8];
  logic [3:0] exp_px;

  initial begin
    n_rst = 1'b0;
    hx = '0; vy = '0; n_pixel_ena = 1'b1;
    text_d = '0; color_d = '0; font_d = '0;

    // reset held with random inputs
    for (int i = 0; i < 12; i++) begin
      txt = 8'($urandom); col = 8'($urandom);
      fnt = 8'($urandom);
      tick($urandom_range(0, 799), $urandom_range(0, 524));
    end
    chk("rst_irgb", 16'(irgb), 16'h0);
    chk("rst_font_a", 16'(font_a), 16'h0);
    chk("rst_blink", 16'(blink_on), 16'h0);
    n_rst = 1'b1;

    // cell 0, line 0
    txt = 8'h41; col = 8'h1E; fnt = 8'hA5;
    exp_a = '{4'hE, 4'h1, 4'hE, 4'h1,
              4'h1, 4'hE, 4'h1, 4'hE};
    for (int h = 0; h < 18; h++) begin
      tick(h, 0);
      if (h == 3)
        chk("c0_font_a", 16'(font_a), 16'h410);
      if (h >= 8 && h < 16)
        chk($sformatf("c0_px%0d", h), 16'(irgb),
            16'(exp_a[h-8]));
    end

    // reset asserted mid-line blanks output at once
    #1 n_rst = 1'b0;
    #1 chk("midrst_irgb", 16'(irgb), 16'h0);
    chk("midrst_font_a", 16'(font_a), 16'h0);
    for (int h = 18; h < 21; h++) tick(h, 0);
    n_rst = 1'b1;
    for (int h = 21; h < 33; h++) begin
      tick(h, 0);
      if (h < 32)
        chk($sformatf("postrst_blank%0d", h),
            16'(irgb), 16'h0);
      else
        chk("postrst_first", 16'(irgb), 16'hE);
    end

    // line 37: font row and vaddr
    for (int h = 0; h < 20; h++) begin
      tick(h, 37);
      if (h == 16)
        chk("l37_vaddr", 16'(vaddr), 16'h102);
      if (h == 19)
        chk("l37_font_a", 16'(font_a), 16'h415);
    end

    // last visible cell and horizontal blanking
    col = 8'h0F; fnt = 8'hFF;
    for (int h = 600; h < 800; h++) begin
      tick(h, 100);
      if (h >= 640 && h < 648)
        chk($sformatf("c79_px%0d", h), 16'(irgb), 16'hF);
      else if (h >= 648 && (h % 16) == 0)
        chk($sformatf("hblank%0d", h), 16'(irgb), 16'h0);
    end
    for (int h = 0; h < 800; h++) begin
      tick(h, 480 + (h % 40));
      if ((h % 50) == 3)
        chk($sformatf("vblank%0d", h), 16'(irgb), 16'h0);
    end

    // blink with BLINK_FRAMES=2
    n_rst = 1'b0;
    tick(0, 0);
    n_rst = 1'b1;
    fnt = 8'hFF;
    for (int f = 0; f < 5; f++) begin
      col = 8'h8F;
      exp_px = (f == 2 || f == 3) ? 4'h0 : 4'hF;
      for (int h = 0; h < 16; h++) begin
        tick(h, 0);
        if (h == 8 || h == 15)
          chk($sformatf("blink_f%0d_px%0d", f, h),
              16'(irgb), 16'(exp_px));
      end
      col = 8'h0F;
      for (int h = 0; h < 16; h++) begin
        tick(h, 1);
        if (h == 8 || h == 15)
          chk($sformatf("noblink_f%0d_px%0d", f, h),
              16'(irgb), 16'hF);
      end
      tick(798, 524);
      tick(799, 524);
      chk($sformatf("blink_pre_f%0d", f), 16'(blink_on),
          16'((f == 2 || f == 3) ? 1 : 0));
      tick(0, 0);
      chk($sformatf("blink_post_f%0d", f), 16'(blink_on),
          16'((f >= 1 && f <= 2) ? 1 : 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
